// File: rtl/mpu_cache_pkg.sv
// rtl/mpu_cache_pkg.sv - shared constants and state encoding for the line-fill controller
package mpu_cache_pkg;

    localparam int LINE_BYTES = 32;
    localparam int OFFSET_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with increment enable
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - single-line cache tag/valid holder and byte-wise line-fill sequencer
module cache_fill_ctrl
    import mpu_cache_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    output logic                cpu_ready,
    output logic                cpu_stall,
    input  logic                flush,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [7:0]          mem_data,
    output logic [7:0]          cache_data,
    output logic [OFFSET_W-1:0] cache_wroffset,
    output logic                cache_wren,
    output logic [OFFSET_W-1:0] cache_rdoffset,
    output logic [CNT_W-1:0]    miss_count
);

    localparam int TAG_W = ADDR_W - OFFSET_W;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;

    logic hit;
    logic start_fill;

    assign hit        = valid_q && (tag_q == cpu_addr[ADDR_W-1:OFFSET_W]);
    assign start_fill = (state_q == IDLE) && cpu_req && !hit && !flush;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        mem_rd     = 1'b0;
        cache_wren = 1'b0;
        unique case (state_q)
            IDLE: begin
                // flush wins over a simultaneous miss; nothing is fetched that cycle
                if (flush) begin
                    valid_d = 1'b0;
                end else if (cpu_req && !hit) begin
                    tag_d   = cpu_addr[ADDR_W-1:OFFSET_W];
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_rd     = 1'b1;
                cache_wren = mem_ack;
                if (mem_ack) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(LINE_BYTES - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // one spare cycle so the last falling-edge RAM write lands before a hit
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            tag_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_miss_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (start_fill),
        .count_o (miss_count)
    );

    assign cpu_ready      = cpu_req && hit && (state_q == IDLE);
    assign cpu_stall      = (state_q != IDLE);
    assign mem_addr       = {tag_q, cnt_q};
    assign cache_data     = mem_data;
    assign cache_wroffset = cnt_q;
    assign cache_rdoffset = cpu_addr[OFFSET_W-1:0];

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - self-checking bench for cache_fill_ctrl against a line-level model
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic [7:0]  cpu_addr;
    logic        cpu_ready;
    logic        cpu_stall;
    logic        flush;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [7:0]  cache_data;
    logic [4:0]  cache_wroffset;
    logic        cache_wren;
    logic [4:0]  cache_rdoffset;
    logic [15:0] miss_count;

    cache_fill_ctrl #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_ready      (cpu_ready),
        .cpu_stall      (cpu_stall),
        .flush          (flush),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .cache_data     (cache_data),
        .cache_wroffset (cache_wroffset),
        .cache_wren     (cache_wren),
        .cache_rdoffset (cache_rdoffset),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // line-level reference: which line is held, how many bytes of a fill have arrived
    bit m_valid, m_filling, m_done;
    int m_tag, m_idx, m_miss;

    logic [7:0] mirror [32];
    bit   s_ready, s_stall, s_mem_rd, s_wren;
    int   s_mem_addr, s_wroff, s_rdoff;

    always @(negedge clk) if (cache_wren) mirror[cache_wroffset] <= cache_data;

    function automatic logic [7:0] mem_byte(input int a);
        int v;
        v = (a * 37 + 11) % 256;
        return v[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_filling = 0; m_done = 0;
        m_tag = 0; m_idx = 0; m_miss = 0;
    endtask

    task automatic check_outputs();
        int  tin;
        bit  hit, idle, exp_ready;
        tin       = int'(cpu_addr) / 32;
        hit       = m_valid && (m_tag == tin);
        idle      = !m_filling && !m_done;
        exp_ready = cpu_req && hit && idle;
        chk("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
        chk("cpu_stall", 32'(cpu_stall), 32'(!idle));
        chk("mem_rd", 32'(mem_rd), 32'(m_filling));
        chk("cache_wren", 32'(cache_wren), 32'(m_filling && mem_ack));
        chk("cache_rdoffset", 32'(cache_rdoffset), 32'(int'(cpu_addr) % 32));
        chk("miss_count", 32'(miss_count), 32'(m_miss));
        if (m_filling) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_tag * 32 + m_idx));
            chk("cache_wroffset", 32'(cache_wroffset), 32'(m_idx));
            chk("cache_data", 32'(cache_data), 32'(mem_byte(m_tag * 32 + m_idx)));
        end
        if (exp_ready && cpu_ready)
            chk("hit_data", 32'(mirror[cache_rdoffset]), 32'(mem_byte(int'(cpu_addr))));
        s_ready = cpu_ready; s_stall = cpu_stall; s_mem_rd = mem_rd; s_wren = cache_wren;
        s_mem_addr = int'(mem_addr); s_wroff = int'(cache_wroffset); s_rdoff = int'(cache_rdoffset);
    endtask

    task automatic model_step();
        int  tin;
        bit  hit;
        tin = int'(cpu_addr) / 32;
        hit = m_valid && (m_tag == tin);
        if (m_filling) begin
            if (mem_ack) begin
                m_idx++;
                if (m_idx == 32) begin
                    m_idx = 0; m_filling = 0; m_done = 1;
                end
            end
        end else if (m_done) begin
            m_done = 0; m_valid = 1;
        end else if (flush) begin
            m_valid = 0;
        end else if (cpu_req && !hit) begin
            m_tag = tin; m_valid = 0; m_idx = 0; m_filling = 1;
            if (m_miss < 65535) m_miss++;
        end
    endtask

    task automatic cycle(input bit req, input logic [7:0] addr, input bit fl, input bit ack);
        cpu_req = req; cpu_addr = addr; flush = fl; mem_ack = ack;
        mem_data = mem_byte(m_tag * 32 + m_idx);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // runs an in-progress fill to completion; acks on every period-th FILL cycle
    task automatic drain(input int period, input int flush_at, output int fill_cycles);
        int fc;
        fc = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 8'h00, fc == flush_at, (fc % period) == (period - 1));
            if (s_mem_rd) fc++;
            if (!s_stall) break;
        end
        chk("drain_done", 32'(s_stall), 32'd0);
        fill_cycles = fc;
    endtask

    typedef struct {
        logic [7:0] addr;
        bit         exp_ready;
        int         exp_miss;
    } vec_t;
    vec_t vt[7];

    initial begin
        int fc, first_stall, first_ready, nbytes;

        vt[0] = '{8'h40, 1'b1, 1};
        vt[1] = '{8'h5F, 1'b1, 1};
        vt[2] = '{8'h52, 1'b1, 1};
        vt[3] = '{8'h60, 1'b0, 2};
        vt[4] = '{8'h7F, 1'b1, 2};
        vt[5] = '{8'h47, 1'b0, 3};
        vt[6] = '{8'h47, 1'b1, 3};

        reset_n = 0; cpu_req = 0; cpu_addr = 0; flush = 0; mem_ack = 0; mem_data = 0;
        model_reset();
        #2;
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_wren", 32'(cache_wren), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        @(negedge clk); reset_n = 1;
        @(posedge clk); #1;

        // first miss on 0x47 with mem_ack held high
        first_stall = -1; first_ready = -1; nbytes = 0;
        for (int k = 0; k < 60; k++) begin
            cycle(1'b1, 8'h47, 1'b0, 1'b1);
            if (s_stall && first_stall < 0) first_stall = k;
            if (s_mem_rd) begin
                chk("lat_mem_addr", 32'(s_mem_addr), 32'(8'h40 + nbytes));
                chk("lat_wroffset", 32'(s_wroff), 32'(nbytes));
                if (s_wren) nbytes++;
            end
            if (s_ready) begin first_ready = k; break; end
        end
        chk("first_stall_cycle", 32'(first_stall), 32'd1);
        chk("first_ready_cycle", 32'(first_ready), 32'd34);
        chk("bytes_written", 32'(nbytes), 32'd32);
        chk("ready_rdoffset", 32'(s_rdoff), 32'd7);
        chk("miss_after_first", 32'(miss_count), 32'd1);

        // hits and misses against the filled line
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, vt[i].addr, 1'b0, 1'b0);
            chk("tbl_ready", 32'(s_ready), 32'(vt[i].exp_ready));
            chk("tbl_mem_rd", 32'(s_mem_rd), 32'd0);
            if (!s_ready) drain(1, -1, fc);
            chk("tbl_miss", 32'(miss_count), 32'(vt[i].exp_miss));
        end

        // flush in IDLE invalidates; next fill is slow and sees a flush mid-fill
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h47, 1'b0, 1'b0);
        chk("post_flush_ready", 32'(s_ready), 32'd0);
        drain(3, 10, fc);
        chk("slow_fill_cycles", 32'(fc), 32'd96);
        cycle(1'b1, 8'h47, 1'b0, 1'b0);
        chk("hit_after_fill_flush", 32'(s_ready), 32'd1);
        chk("miss_after_slow", 32'(miss_count), 32'd4);

        // flush together with a miss request: no fill starts
        cycle(1'b1, 8'h80, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_miss_stall", 32'(s_stall), 32'd0);
        chk("flush_miss_count", 32'(miss_count), 32'd4);

        // reset mid-fill at FILL cycle 15
        cycle(1'b1, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        reset_n = 0;
        #1;
        chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
        chk("midrst_stall", 32'(cpu_stall), 32'd0);
        chk("midrst_miss", 32'(miss_count), 32'd0);
        model_reset();
        @(negedge clk); reset_n = 1;
        @(posedge clk); #1;
        cycle(1'b1, 8'h80, 1'b0, 1'b0);
        chk("refetch_ready", 32'(s_ready), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("refetch_addr", 32'(s_mem_addr), 32'h80);
        chk("refetch_off", 32'(s_wroff), 32'd0);
        drain(1, -1, fc);
        cycle(1'b1, 8'h9A, 1'b0, 1'b0);
        chk("refetch_hit", 32'(s_ready), 32'd1);

        // randomized traffic over a few lines
        for (int i = 0; i < 1500; i++) begin
            int t;
            logic [7:0] a;
            t = $urandom_range(0, 2);
            a = 8'(((t == 0) ? 0 : (t == 1) ? 2 : 5) * 32 + $urandom_range(0, 31));
            cycle($urandom_range(0, 9) < 6, a, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 9) < 6);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
